// File: rtl/rwc_irq_bank.sv
// Bank of W1C status registers with per-bit logic set, RW masks, overflow capture and a
// level or pulse interrupt derived from masked pending status.
module rwc_irq_bank #(
    parameter int unsigned             DW                   = 8,
    parameter int unsigned             AW                   = 8,
    parameter int unsigned             NUM_REG              = 4,
    parameter int unsigned             BASE_ADDR            = 0,
    parameter logic [NUM_REG*DW-1:0]   STAT_DEFAULT         = '0,
    parameter logic [NUM_REG*DW-1:0]   MASK_DEFAULT         = '0,
    parameter bit                      SUPPORT_TEST_MODE_WR = 1'b1,
    parameter bit                      SUPPORT_TEST_MODE_RD = 1'b1,
    parameter bit                      SUPPORT_CFG_MODE_WR  = 1'b1,
    parameter bit                      SUPPORT_CFG_MODE_RD  = 1'b1,
    parameter bit                      IRQ_MODE             = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wen,
    input  logic                  i_ren,
    input  logic                  i_test_mode_status,
    input  logic                  i_cfg_mode_status,
    input  logic [AW-1:0]         i_addr,
    input  logic [DW-1:0]         i_wdata,
    output logic [DW-1:0]         o_rdata,
    input  logic [NUM_REG*DW-1:0] i_lgc_wen,
    input  logic [NUM_REG*DW-1:0] i_lgc_wdata,
    output logic                  o_irq,
    output logic [NUM_REG-1:0]    o_irq_vec
);

    logic                         wr_ok;
    logic                         rd_ok;
    logic [31:0]                  addr_ext;
    logic [NUM_REG-1:0]           stat_hit;
    logic [NUM_REG-1:0]           mask_hit;
    logic [NUM_REG-1:0]           ovf_hit;
    logic [NUM_REG-1:0][DW-1:0]   set_ev;
    logic [NUM_REG-1:0][DW-1:0]   stat_clr;
    logic [NUM_REG-1:0][DW-1:0]   ovf_clr;
    logic [NUM_REG-1:0][DW-1:0]   stat_q, stat_d;
    logic [NUM_REG-1:0][DW-1:0]   mask_q, mask_d;
    logic [NUM_REG-1:0][DW-1:0]   ovf_q, ovf_d;
    logic [NUM_REG-1:0]           irq_vec_d;
    logic                         irq_lvl_q, irq_lvl_d;
    logic                         irq_lvl_d1_q;

    assign wr_ok = i_wen & ((i_test_mode_status & SUPPORT_TEST_MODE_WR) |
                            (i_cfg_mode_status & SUPPORT_CFG_MODE_WR));
    assign rd_ok = i_ren & ((i_test_mode_status & SUPPORT_TEST_MODE_RD) |
                            (i_cfg_mode_status & SUPPORT_CFG_MODE_RD));

    assign addr_ext = 32'(i_addr);
    assign set_ev   = i_lgc_wen & i_lgc_wdata;

    always_comb begin
        stat_hit = '0;
        mask_hit = '0;
        ovf_hit  = '0;
        for (int unsigned k = 0; k < NUM_REG; k++) begin
            stat_hit[k] = (addr_ext == BASE_ADDR + k);
            mask_hit[k] = (addr_ext == BASE_ADDR + NUM_REG + k);
            ovf_hit[k]  = (addr_ext == BASE_ADDR + 2 * NUM_REG + k);
        end
    end

    always_comb begin
        stat_clr  = '0;
        ovf_clr   = '0;
        stat_d    = stat_q;
        mask_d    = mask_q;
        ovf_d     = ovf_q;
        irq_vec_d = '0;
        for (int unsigned k = 0; k < NUM_REG; k++) begin
            if (wr_ok && stat_hit[k]) stat_clr[k] = i_wdata;
            if (wr_ok && ovf_hit[k])  ovf_clr[k]  = i_wdata;
            if (wr_ok && mask_hit[k]) mask_d[k]   = i_wdata;
            // Set always beats a same-cycle W1C; overflow only counts a set on a bit that stays 1.
            stat_d[k]    = set_ev[k] | (stat_q[k] & ~stat_clr[k]);
            ovf_d[k]     = (set_ev[k] & stat_q[k] & ~stat_clr[k]) | (ovf_q[k] & ~ovf_clr[k]);
            irq_vec_d[k] = |(stat_q[k] & mask_q[k]);
        end
    end

    assign irq_lvl_d = |irq_vec_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_q       <= STAT_DEFAULT;
            mask_q       <= MASK_DEFAULT;
            ovf_q        <= '0;
            o_irq_vec    <= '0;
            irq_lvl_q    <= 1'b0;
            irq_lvl_d1_q <= 1'b0;
        end else begin
            stat_q       <= stat_d;
            mask_q       <= mask_d;
            ovf_q        <= ovf_d;
            o_irq_vec    <= irq_vec_d;
            irq_lvl_q    <= irq_lvl_d;
            irq_lvl_d1_q <= irq_lvl_q;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (rd_ok) begin
            for (int unsigned k = 0; k < NUM_REG; k++) begin
                if (stat_hit[k]) o_rdata = stat_q[k];
                if (mask_hit[k]) o_rdata = mask_q[k];
                if (ovf_hit[k])  o_rdata = ovf_q[k];
            end
        end
    end

    assign o_irq = IRQ_MODE ? (irq_lvl_q & ~irq_lvl_d1_q) : irq_lvl_q;

endmodule

// File: tb/tb_rwc_irq_bank.sv
// Directed bench for rwc_irq_bank: a level-mode instance and a pulse-mode instance with
// cfg-mode writes disabled, checked through an expected-value queue.
module tb_rwc_irq_bank;

    logic        clk;
    logic        rst_n     [2];
    logic        wen       [2];
    logic        ren       [2];
    logic        tm        [2];
    logic        cfg       [2];
    logic [7:0]  addr      [2];
    logic [7:0]  wdata     [2];
    logic [7:0]  rdata     [2];
    logic [31:0] lgc_wen   [2];
    logic [31:0] lgc_wdata [2];
    logic        irq       [2];
    logic [3:0]  vec       [2];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rwc_irq_bank #(
        .DW(8), .AW(8), .NUM_REG(4), .BASE_ADDR(32'h10),
        .STAT_DEFAULT(32'h0400_0000), .MASK_DEFAULT(32'h0000_0080),
        .IRQ_MODE(1'b0)
    ) u_lvl (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_wen(wen[0]), .i_ren(ren[0]),
        .i_test_mode_status(tm[0]), .i_cfg_mode_status(cfg[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]),
        .i_lgc_wen(lgc_wen[0]), .i_lgc_wdata(lgc_wdata[0]),
        .o_irq(irq[0]), .o_irq_vec(vec[0])
    );

    rwc_irq_bank #(
        .DW(8), .AW(8), .NUM_REG(4), .BASE_ADDR(32'h10),
        .STAT_DEFAULT(32'h0000_0001), .MASK_DEFAULT(32'h0000_0001),
        .SUPPORT_CFG_MODE_WR(1'b0), .IRQ_MODE(1'b1)
    ) u_pls (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_wen(wen[1]), .i_ren(ren[1]),
        .i_test_mode_status(tm[1]), .i_cfg_mode_status(cfg[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]),
        .i_lgc_wen(lgc_wen[1]), .i_lgc_wdata(lgc_wdata[1]),
        .o_irq(irq[1]), .o_irq_vec(vec[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty observed=%h required=queued_entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle(input int d);
        wen[d]       = 1'b0;
        ren[d]       = 1'b0;
        tm[d]        = 1'b0;
        cfg[d]       = 1'b0;
        addr[d]      = 8'h00;
        wdata[d]     = 8'h00;
        lgc_wen[d]   = 32'h0;
        lgc_wdata[d] = 32'h0;
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [7:0] v,
                      input logic t, input logic c);
        wen[d]   = 1'b1;
        addr[d]  = a;
        wdata[d] = v;
        tm[d]    = t;
        cfg[d]   = c;
        tick();
        idle(d);
    endtask

    task automatic rd(input int d, input string tag, input logic [7:0] a, input logic [7:0] e,
                      input logic t, input logic c);
        push(tag, 32'(e));
        ren[d]  = 1'b1;
        addr[d] = a;
        tm[d]   = t;
        cfg[d]  = c;
        #1;
        chk(32'(rdata[d]));
        idle(d);
    endtask

    task automatic set_bits(input int d, input logic [31:0] v);
        lgc_wen[d]   = v;
        lgc_wdata[d] = v;
        tick();
        idle(d);
    endtask

    // Drives a logic set on channel bits at step 0 (and optionally step 3), counts o_irq highs.
    task automatic pulse_window(input int d, input logic [31:0] s0, input logic [31:0] s3,
                                input int steps, output int cnt);
        cnt = 0;
        for (int i = 0; i < steps; i++) begin
            lgc_wen[d]   = (i == 0) ? s0 : ((i == 3) ? s3 : 32'h0);
            lgc_wdata[d] = lgc_wen[d];
            tick();
            if (irq[d]) cnt++;
        end
        idle(d);
    endtask

    int cnt;

    initial begin
        idle(0);
        idle(1);
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (2) tick();
        push("a_rst_irq", 0);      chk(32'(irq[0]));
        push("a_rst_vec", 0);      chk(32'(vec[0]));
        push("b_rst_irq", 0);      chk(32'(irq[1]));

        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        push("b_release_pulse", 1);    push("b_release_vec", 32'h1);  push("a_release_irq", 0);
        tick();
        chk(32'(irq[1]));
        chk(32'(vec[1]));
        chk(32'(irq[0]));
        push("b_release_pulse_end", 0);
        tick();
        chk(32'(irq[1]));

        // Level instance: defaults, set gating, first transaction
        rd(0, "a_def_stat3", 8'h13, 8'h04, 1'b0, 1'b1);
        rd(0, "a_def_mask0", 8'h14, 8'h80, 1'b1, 1'b0);
        rd(0, "a_def_ovf0", 8'h18, 8'h00, 1'b0, 1'b1);
        tick();
        lgc_wdata[0] = 32'hFFFF_FFFF;
        tick();
        lgc_wdata[0] = 32'h0;
        lgc_wen[0]   = 32'hFFFF_FFFF;
        tick();
        idle(0);
        rd(0, "a_set_needs_both", 8'h11, 8'h00, 1'b0, 1'b1);
        tick();

        set_bits(0, 32'h0000_0800);
        rd(0, "a_stat1_set", 8'h11, 8'h08, 1'b0, 1'b1);
        rd(0, "a_mask1_zero", 8'h15, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        push("a_irq_masked", 0);   chk(32'(irq[0]));
        push("a_vec_masked", 0);   chk(32'(vec[0]));

        push("a_irq_unmask_1cyc", 0);
        wr(0, 8'h15, 8'h08, 1'b0, 1'b1);
        chk(32'(irq[0]));
        push("a_irq_unmask_2cyc", 1);  push("a_vec_unmask", 32'b0010);
        tick();
        chk(32'(irq[0]));
        chk(32'(vec[0]));

        push("a_irq_clr_1cyc", 1);
        wr(0, 8'h11, 8'h08, 1'b0, 1'b1);
        chk(32'(irq[0]));
        push("a_irq_clr_2cyc", 0);
        tick();
        chk(32'(irq[0]));
        rd(0, "a_stat1_cleared", 8'h11, 8'h00, 1'b0, 1'b1);

        // Overflow capture and set-over-clear
        set_bits(0, 32'h0000_0800);
        rd(0, "a_ovf1_first_set", 8'h19, 8'h00, 1'b0, 1'b1);
        set_bits(0, 32'h0000_0800);
        rd(0, "a_ovf1_second_set", 8'h19, 8'h08, 1'b0, 1'b1);
        wr(0, 8'h19, 8'h08, 1'b0, 1'b1);
        rd(0, "a_ovf1_w1c", 8'h19, 8'h00, 1'b0, 1'b1);
        rd(0, "a_stat1_after_ovfclr", 8'h11, 8'h08, 1'b0, 1'b1);
        wr(0, 8'h11, 8'hF7, 1'b0, 1'b1);
        rd(0, "a_stat1_w0_keeps", 8'h11, 8'h08, 1'b0, 1'b1);

        set_bits(0, 32'h0001_0000);
        lgc_wen[0]   = 32'h0001_0000;
        lgc_wdata[0] = 32'h0001_0000;
        wen[0]       = 1'b1;
        cfg[0]       = 1'b1;
        addr[0]      = 8'h12;
        wdata[0]     = 8'h01;
        tick();
        idle(0);
        rd(0, "a_stat2_set_wins", 8'h12, 8'h01, 1'b0, 1'b1);
        rd(0, "a_ovf2_unchanged", 8'h1A, 8'h00, 1'b0, 1'b1);
        wr(0, 8'h12, 8'h01, 1'b0, 1'b1);
        rd(0, "a_stat2_cleared", 8'h12, 8'h00, 1'b0, 1'b1);

        // Mode gating and address range
        rd(0, "a_rd_nomode", 8'h11, 8'h00, 1'b0, 1'b0);
        rd(0, "a_rd_testmode", 8'h11, 8'h08, 1'b1, 1'b0);
        wr(0, 8'h15, 8'hFF, 1'b0, 1'b0);
        rd(0, "a_wr_nomode", 8'h15, 8'h08, 1'b0, 1'b1);
        set_bits(0, 32'h0400_0000);
        wr(0, 8'h30, 8'hFF, 1'b0, 1'b1);
        wr(0, 8'h1C, 8'hFF, 1'b0, 1'b1);
        rd(0, "a_rd_0x30", 8'h30, 8'h00, 1'b0, 1'b1);
        rd(0, "a_rd_0x1C", 8'h1C, 8'h00, 1'b0, 1'b1);
        rd(0, "a_rd_0x0F", 8'h0F, 8'h00, 1'b0, 1'b1);
        tick();
        rd(0, "a_ovf3_last_addr", 8'h1B, 8'h04, 1'b0, 1'b1);

        // Asynchronous reset mid-operation
        set_bits(0, 32'h0000_00FF);
        set_bits(0, 32'h0000_0001);
        rd(0, "a_ovf0_pre_rst", 8'h18, 8'h01, 1'b0, 1'b1);
        tick();
        tick();
        push("a_irq_pre_rst", 1);  chk(32'(irq[0]));
        #2;
        rst_n[0] = 1'b0;
        #1;
        push("a_irq_async_rst", 0); chk(32'(irq[0]));
        push("a_vec_async_rst", 0); chk(32'(vec[0]));
        rd(0, "a_stat0_in_rst", 8'h10, 8'h00, 1'b0, 1'b1);
        lgc_wen[0]   = 32'hFFFF_FFFF;
        lgc_wdata[0] = 32'hFFFF_FFFF;
        tick();
        idle(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        tick();
        rd(0, "a_post_stat0", 8'h10, 8'h00, 1'b0, 1'b1);
        rd(0, "a_post_stat3", 8'h13, 8'h04, 1'b0, 1'b1);
        rd(0, "a_post_mask0", 8'h14, 8'h80, 1'b0, 1'b1);
        tick();
        rd(0, "a_post_mask1", 8'h15, 8'h00, 1'b0, 1'b1);
        rd(0, "a_post_ovf0", 8'h18, 8'h00, 1'b0, 1'b1);
        rd(0, "a_post_ovf1", 8'h19, 8'h00, 1'b0, 1'b1);
        tick();
        push("a_post_irq", 0);     chk(32'(irq[0]));

        // Pulse instance: cfg-only writes are blocked
        wr(1, 8'h14, 8'h00, 1'b0, 1'b1);
        rd(1, "b_cfg_wr_blocked", 8'h14, 8'h01, 1'b0, 1'b1);
        wr(1, 8'h14, 8'h00, 1'b1, 1'b0);
        rd(1, "b_test_wr_ok", 8'h14, 8'h00, 1'b1, 1'b0);
        wr(1, 8'h10, 8'h01, 1'b1, 1'b0);
        tick();
        tick();
        push("b_vec_idle", 0);     chk(32'(vec[1]));
        wr(1, 8'h15, 8'hFF, 1'b1, 1'b0);
        wr(1, 8'h16, 8'hFF, 1'b1, 1'b0);

        push("b_one_pulse_two_ch", 1);
        pulse_window(1, 32'h0000_0100, 32'h0001_0000, 10, cnt);
        chk(32'(cnt));
        push("b_vec_both", 32'b0110); chk(32'(vec[1]));

        push("b_no_pulse_while_high", 0);
        pulse_window(1, 32'h0000_0100, 32'h0, 5, cnt);
        chk(32'(cnt));
        rd(1, "b_ovf1_recorded", 8'h19, 8'h01, 1'b0, 1'b1);

        wr(1, 8'h11, 8'h01, 1'b1, 1'b0);
        wr(1, 8'h12, 8'h01, 1'b1, 1'b0);
        repeat (3) tick();
        push("b_vec_cleared", 0);  chk(32'(vec[1]));
        push("b_irq_cleared", 0);  chk(32'(irq[1]));

        push("b_second_pulse", 1);
        pulse_window(1, 32'h0001_0000, 32'h0, 6, cnt);
        chk(32'(cnt));

        push("sb_drained", 0);
        chk(32'(sb.size() - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rwc_irq_bank.md
RWC_IRQ_BANK -- requirements
Module: rwc_irq_bank

Interface
REQ-001 Parameter DW, default 8: data width of every register.
REQ-002 Parameter AW, default 8: address width.
REQ-003 Parameter NUM_REG, default 4: number of status channels (1..16).
REQ-004 Parameter BASE_ADDR, default 0: status reg k at BASE_ADDR+k; mask reg k at BASE_ADDR+NUM_REG+k; overflow reg k at BASE_ADDR+2*NUM_REG+k.
REQ-005 Parameter STAT_DEFAULT, default all-0 (NUM_REG*DW bits): status reset value; slice k applies to reg k.
REQ-006 Parameter MASK_DEFAULT, default all-0 (NUM_REG*DW bits): mask reset value.
REQ-007 Parameter SUPPORT_TEST_MODE_WR / _RD / SUPPORT_CFG_MODE_WR / _RD, default 1 each: mode gating of CPU access.
REQ-008 Parameter IRQ_MODE, default 0: 0 = level interrupt, 1 = single-cycle pulse interrupt.
REQ-009 i_clk  in  1  sole clock, rising edge.
REQ-010 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-011 i_wen / i_ren  in  1  CPU write / read strobe.
REQ-012 i_test_mode_status / i_cfg_mode_status  in  1  mode qualifiers.
REQ-013 i_addr  in  AW  CPU address; i_wdata  in  DW  CPU write data.
REQ-014 o_rdata  out  DW  CPU read data.
REQ-015 i_lgc_wen / i_lgc_wdata  in  NUM_REG*DW  per-bit logic set strobe / data.
REQ-016 o_irq  out  1  interrupt; o_irq_vec  out  NUM_REG  per-channel masked-pending level.

Function
REQ-017 Access qualifier: wr_ok = i_wen & ((i_test_mode_status & SUPPORT_TEST_MODE_WR) | (i_cfg_mode_status & SUPPORT_CFG_MODE_WR)); rd_ok likewise with i_ren and _RD parameters.
REQ-018 Set event per bit = i_lgc_wen & i_lgc_wdata; applies regardless of mode and address.
REQ-019 Status bit: set event -> 1 next cycle; else wr_ok, address hits status k and i_wdata bit=1 -> 0; else hold (W1C, set wins).
REQ-020 Mask reg: plain RW; wr_ok and address hit -> loads i_wdata next cycle.
REQ-021 Overflow bit: set event while status bit is 1 and not being cleared this cycle -> 1; W1C at overflow address; set wins over clear.
REQ-022 Set event in the same cycle as a CPU clear of that status bit: status stays 1, overflow unchanged.
REQ-023 o_rdata combinational: rd_ok with address hit -> selected register; otherwise all-0.
REQ-024 Out-of-range address (not in BASE_ADDR..BASE_ADDR+3*NUM_REG-1): write ignored, read returns 0.
REQ-025 o_irq_vec[k] registered: next-cycle value of |(status_k & mask_k), computed from current register outputs.
REQ-026 irq_lvl registered = |o_irq_vec inputs (same cycle as o_irq_vec update); set pulse in cycle N -> status in N+1 -> o_irq_vec/irq_lvl in N+2.
REQ-027 IRQ_MODE=0: o_irq = irq_lvl; IRQ_MODE=1: o_irq = irq_lvl & ~irq_lvl_d1 (one-cycle pulse per 0->1 transition of irq_lvl).
REQ-028 In pulse mode a new event while irq_lvl stays 1 produces no new pulse; only the overflow bit records it.
REQ-029 Unmasking an already-pending bit raises irq_lvl two cycles after the mask write cycle.

Reset
REQ-030 While i_rst_n=0: status = STAT_DEFAULT, mask = MASK_DEFAULT, overflow = 0, o_irq_vec = 0, irq_lvl = irq_lvl_d1 = 0, o_irq = 0.
REQ-031 Reset asserted mid-operation discards pending events in the same cycle; no pulse is emitted on release unless it results from post-release register state (reset STAT_DEFAULT & MASK_DEFAULT nonzero -> irq_lvl 1 and one pulse in mode 1 at 1st edge after release).

Verification
REQ-032 DW=8, NUM_REG=4, BASE_ADDR=0x10: set ch1 bit3 pulse -> read 0x11 = 0x08; read 0x15 = 0x00; o_irq stays 0 (mask 0).
REQ-033 Write 0x15=0x08 in cfg mode -> o_irq_vec=4'b0010 and o_irq=1 two cycles later; write 0x11=0x08 -> status 0, o_irq 0 two cycles after clear.
REQ-034 Second set of ch1 bit3 while pending -> read 0x19 = 0x08; same-cycle set+clear of ch2 bit0 -> 0x12 reads 0x01, 0x1A reads 0x00.
REQ-035 IRQ_MODE=1: two channels set 3 cycles apart with both unmasked -> exactly one o_irq pulse; clear both, set again -> second pulse.
REQ-036 Mode gating: SUPPORT_CFG_MODE_WR=0, cfg-only write to 0x14 -> mask unchanged; read 0x30 -> 0x00; rd with both mode inputs 0 -> 0x00.
REQ-037 Reset asserted with status 0xFF, overflow 0x01 -> all outputs 0 asynchronously; after release reads return STAT_DEFAULT / MASK_DEFAULT / 0.
